lsu_dccm_bank_arb: RTL and testbench
====================================

# lsu_dccm_bank_arb

Parametrised DCCM bank arbiter and read pipeline for the LSU. It generalises the fixed two-bank DCCM port control to N banks of configurable width. It arbitrates DC1 load reads against store-buffer commits and a new ECC-correction write-back queue, with a starvation counter that guarantees write forward progress. It sits between the LSU DC1–DC3 pipe and the DCCM bank macros.

## Interface
- DATA_WIDTH, 32: data bits per bank word; power of 2, ≥32.
- ECC_WIDTH, 7: ECC bits per bank word; FDATA = DATA_WIDTH+ECC_WIDTH.
- NUM_BANKS, 2: bank count; power of 2, ≥2.
- ADDR_BITS, 16: DCCM byte-address width.
- STARVE_MAX, 4: consecutive write losses before writes take priority; 1–15.
- CORR_DEPTH, 2: correction queue entries; ≥1.

Ports:
- clk  in  1  core clock.
- rst_l  in  1  reset; one clock, reset is asynchronous and active-low.
- freeze  in  1  pipeline freeze.
- ld_valid_dc1  in  1  load/RMW read request.
- ld_addr_dc1, ld_end_addr_dc1  in  ADDR_BITS each  first and last byte address.
- ld_stall_dc1  out  1  request not granted; the requester retries next cycle.
- sb_valid  in  1  store-buffer head valid.
- sb_addr  in  ADDR_BITS  store-buffer head address, word-aligned.
- sb_wdata  in  FDATA  store-buffer head data with ECC.
- sb_commit  out  1  store-buffer head written this cycle.
- corr_valid_dc3  in  1  corrected word push.
- corr_addr_dc3  in  ADDR_BITS  corrected word address.
- corr_wdata_dc3  in  FDATA  corrected word data with ECC.
- corr_overflow  out  1  pulse when a push is dropped.
- bank_rden, bank_wren  out  NUM_BANKS each  per-bank strobes.
- bank_addr  out  NUM_BANKS*ADDR_BITS  per-bank address, flat.
- bank_wdata  out  NUM_BANKS*FDATA  per-bank write data, flat.
- bank_rdata  in  NUM_BANKS*FDATA  per-bank read data, valid the cycle after bank_rden.
- rd_valid_dc3  out  1  load data valid.
- rd_data_lo_dc3, rd_data_hi_dc3  out  FDATA each  data for the first and last address.

## Operation
- Bank index: bank(a) = a[WB +: log2(NUM_BANKS)], where WB = log2(DATA_WIDTH/8).
- Load bank set: L = {bank(ld_addr_dc1), bank(ld_end_addr_dc1)}. If both addresses map to the same bank, L has one bank.
- Write candidate: the correction-queue head if the queue is non-empty, else the store buffer if sb_valid. Only one write is issued per cycle. Its bank is W.
- Normal mode (starve_cnt < STARVE_MAX):
  - The load wins.
  - The write is granted only if W ∉ L.
- Starve mode (starve_cnt == STARVE_MAX):
  - The write wins.
  - If W ∈ L, the load is stalled (ld_stall_dc1=1, no bank_rden).
- starve_cnt:
  - Increments when a write candidate exists and is not granted (saturates at STARVE_MAX).
  - Clears on any write grant, or when no write candidate exists.
- Granted store-buffer write → sb_commit=1. Granted correction write → queue pop; sb_commit=0.
- freeze=1:
  - No bank_rden or bank_wren.
  - ld_stall_dc1 = ld_valid_dc1; sb_commit=0; no pop.
  - DC2/DC3 registers hold; starve_cnt holds.
  - Correction-queue pushes are still accepted.
- Correction queue (FIFO):
  - Push accepted if count < CORR_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the push is dropped and corr_overflow pulses for one cycle.
- Read path:
  - DC1 grant sets v_dc2 and captures the two bank indices.
  - In DC2, bank_rdata of the captured banks is flopped into the DC3 data registers.
  - rd_valid_dc3 = v_dc3.
  - When both addresses map to one bank, lo and hi carry the same word.
- Unused bank_addr/bank_wdata lanes drive 0.

## Timing
- Arbitration and bank strobes are combinational from DC1 inputs; there are no registered outputs on the request side.
- Load latency: grant in cycle N → rd_valid_dc3 and data in cycle N+2, absent freeze. Each freeze cycle adds one cycle.
- Reset (rst_l=0, asynchronous):
  - v_dc2, v_dc3, rd_data_*_dc3, starve_cnt, queue count and pointers, corr_overflow all 0.
  - All combinational outputs are 0 while ld_valid_dc1, sb_valid and the queue are idle.
- Reset mid-operation: in-flight loads are discarded (no rd_valid_dc3); queued corrections are lost.
- Pointers wrap modulo CORR_DEPTH. Non-power-of-2 depths are supported via explicit compare-and-clear.
- A push and a pop on an empty queue in the same cycle: the pop is not possible (the head is invalid), so the push lands normally.

## Structure
- swerv_types gains lsu_dccm_bank_req_t {valid, write, addr, wdata}, shared with the bank macro wrapper.
- The bank-index function and the WB constant go in global.h-style shared constants.
- Sub-module lsu_dccm_corr_fifo: parametrised by depth and width. Ports: push, pop, full, empty, head, and an overflow pulse. Registers use the async-reset rvdffs variants.

## Test plan
- NUM_BANKS=4: load 0x0 (bank 0) with a store to 0x8 (bank 2) → both granted same cycle; rd_valid_dc3 at N+2.
- Load 0x2, end 0x5 (banks 0,1), store to 0x4 → store denied 4 consecutive cycles. Cycle 5: sb_commit=1, ld_stall_dc1=1, starve_cnt→0.
- Correction push to 0x10 and sb_valid to 0x14 with no load → correction written first, store next cycle.
- CORR_DEPTH=2: three pushes with no drain → third dropped, corr_overflow=1 for one cycle. Push plus pop at full → accepted.
- freeze held 3 cycles after a load grant → rd_valid_dc3 appears at N+5; no bank strobes during freeze.
- Assert rst_l=0 with v_dc2=1 → rd_valid_dc3 never asserts; all state 0 after release.

Source files
------------

// File: rtl/lsu_dccm_bank_arb_pkg.sv
// Shared types and bank-index helpers for the DCCM bank arbiter.
package lsu_dccm_bank_arb_pkg;

  typedef enum logic [1:0] {WrNone, WrSb, WrCorr} wr_src_e;

  // Byte-offset bits within one bank word.
  function automatic int unsigned bank_wb(int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int unsigned bank_of(logic [31:0] addr, int unsigned wb, int unsigned nb);
    return (addr >> wb) & (nb - 1);
  endfunction

endpackage

// File: rtl/lsu_dccm_corr_fifo.sv
// ECC-correction write-back FIFO; drops pushes when full and no pop frees a slot.
module lsu_dccm_corr_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic             overflow
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q;
  logic             pop_ok, push_ok;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DEPTH));
  assign head     = mem_q[rd_ptr_q];
  assign overflow = ovf_q;
  // A pop on an empty queue is meaningless, so it never frees a slot.
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      cnt_d = cnt_q + 1'b1;
    else if (!push_ok && pop_ok) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= push && !push_ok;
      if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/lsu_dccm_bank_arb.sv
// N-bank DCCM arbiter: DC1 loads vs. store-buffer/correction writes, plus DC2/DC3 read pipe.
module lsu_dccm_bank_arb
  import lsu_dccm_bank_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ECC_WIDTH  = 7,
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned ADDR_BITS  = 16,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CORR_DEPTH = 2,
  localparam int unsigned FDATA     = DATA_WIDTH + ECC_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_l,
  input  logic                           freeze,
  input  logic                           ld_valid_dc1,
  input  logic [ADDR_BITS-1:0]           ld_addr_dc1,
  input  logic [ADDR_BITS-1:0]           ld_end_addr_dc1,
  output logic                           ld_stall_dc1,
  input  logic                           sb_valid,
  input  logic [ADDR_BITS-1:0]           sb_addr,
  input  logic [FDATA-1:0]               sb_wdata,
  output logic                           sb_commit,
  input  logic                           corr_valid_dc3,
  input  logic [ADDR_BITS-1:0]           corr_addr_dc3,
  input  logic [FDATA-1:0]               corr_wdata_dc3,
  output logic                           corr_overflow,
  output logic [NUM_BANKS-1:0]           bank_rden,
  output logic [NUM_BANKS-1:0]           bank_wren,
  output logic [NUM_BANKS*ADDR_BITS-1:0] bank_addr,
  output logic [NUM_BANKS*FDATA-1:0]     bank_wdata,
  input  logic [NUM_BANKS*FDATA-1:0]     bank_rdata,
  output logic                           rd_valid_dc3,
  output logic [FDATA-1:0]               rd_data_lo_dc3,
  output logic [FDATA-1:0]               rd_data_hi_dc3
);
  localparam int unsigned WB = bank_wb(DATA_WIDTH);
  localparam int unsigned BB = $clog2(NUM_BANKS);
  localparam int unsigned QW = ADDR_BITS + FDATA;

  logic [BB-1:0]        ld_bank_lo, ld_bank_hi, wr_bank;
  logic [BB-1:0]        bank_lo_dc2_q, bank_hi_dc2_q;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [FDATA-1:0]     wr_data;
  logic [QW-1:0]        corr_head;
  logic                 corr_empty, unused_corr_full, corr_pop;
  wr_src_e              wr_src;
  logic                 wr_cand, ld_hits_w, starve, ld_grant, wr_grant;
  logic [3:0]           starve_q, starve_d;
  logic                 v_dc2_q, v_dc3_q;
  logic [FDATA-1:0]     rd_lo_q, rd_hi_q;

  lsu_dccm_corr_fifo #(
    .DEPTH(CORR_DEPTH),
    .WIDTH(QW)
  ) u_corr_fifo (
    .clk     (clk),
    .rst_l   (rst_l),
    .push    (corr_valid_dc3),
    .wdata   ({corr_addr_dc3, corr_wdata_dc3}),
    .pop     (corr_pop),
    .full    (unused_corr_full),
    .empty   (corr_empty),
    .head    (corr_head),
    .overflow(corr_overflow)
  );

  always_comb begin
    ld_bank_lo = BB'(bank_of(32'(ld_addr_dc1), WB, NUM_BANKS));
    ld_bank_hi = BB'(bank_of(32'(ld_end_addr_dc1), WB, NUM_BANKS));
    wr_src     = !corr_empty ? WrCorr : (sb_valid ? WrSb : WrNone);
    wr_addr    = (wr_src == WrCorr) ? corr_head[QW-1:FDATA] : sb_addr;
    wr_data    = (wr_src == WrCorr) ? corr_head[FDATA-1:0] : sb_wdata;
    wr_bank    = BB'(bank_of(32'(wr_addr), WB, NUM_BANKS));
    wr_cand    = (wr_src != WrNone);
    ld_hits_w  = ld_valid_dc1 && ((wr_bank == ld_bank_lo) || (wr_bank == ld_bank_hi));
    starve     = (starve_q == 4'(STARVE_MAX));
    // Starve mode flips priority: the load yields only if it actually shares the write bank.
    ld_grant   = ld_valid_dc1 && !freeze && !(starve && wr_cand && ld_hits_w);
    wr_grant   = wr_cand && !freeze && (starve || !ld_hits_w);
    ld_stall_dc1 = ld_valid_dc1 && !ld_grant;
    sb_commit  = wr_grant && (wr_src == WrSb);
    corr_pop   = wr_grant && (wr_src == WrCorr);

    starve_d = starve_q;
    if (!freeze) begin
      if (!wr_cand || wr_grant) starve_d = '0;
      else if (!starve)         starve_d = starve_q + 1'b1;
    end
  end

  always_comb begin
    bank_rden  = '0;
    bank_wren  = '0;
    bank_addr  = '0;
    bank_wdata = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (wr_grant && (wr_bank == BB'(b))) begin
        bank_wren[b]                    = 1'b1;
        bank_addr[b*ADDR_BITS +: ADDR_BITS] = wr_addr;
        bank_wdata[b*FDATA +: FDATA]    = wr_data;
      end else if (ld_grant && (ld_bank_lo == BB'(b))) begin
        bank_rden[b]                    = 1'b1;
        bank_addr[b*ADDR_BITS +: ADDR_BITS] = ld_addr_dc1;
      end else if (ld_grant && (ld_bank_hi == BB'(b))) begin
        bank_rden[b]                    = 1'b1;
        bank_addr[b*ADDR_BITS +: ADDR_BITS] = ld_end_addr_dc1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      starve_q      <= '0;
      v_dc2_q       <= 1'b0;
      v_dc3_q       <= 1'b0;
      bank_lo_dc2_q <= '0;
      bank_hi_dc2_q <= '0;
      rd_lo_q       <= '0;
      rd_hi_q       <= '0;
    end else if (!freeze) begin
      starve_q <= starve_d;
      v_dc2_q  <= ld_grant;
      v_dc3_q  <= v_dc2_q;
      if (ld_grant) begin
        bank_lo_dc2_q <= ld_bank_lo;
        bank_hi_dc2_q <= ld_bank_hi;
      end
      if (v_dc2_q) begin
        rd_lo_q <= bank_rdata[bank_lo_dc2_q*FDATA +: FDATA];
        rd_hi_q <= bank_rdata[bank_hi_dc2_q*FDATA +: FDATA];
      end
    end
  end

  assign rd_valid_dc3   = v_dc3_q;
  assign rd_data_lo_dc3 = rd_lo_q;
  assign rd_data_hi_dc3 = rd_hi_q;

endmodule

// File: tb/tb_lsu_dccm_bank_arb.sv
// Directed bench for the DCCM bank arbiter with a read-data scoreboard.
module tb_lsu_dccm_bank_arb;
  localparam int unsigned DW = 32, EW = 7, NB = 4, AB = 16, SM = 4, CD = 2;
  localparam int unsigned FD = DW + EW;

  logic             clk = 1'b0;
  logic             rst_l, freeze;
  logic             ld_valid_dc1, ld_stall_dc1;
  logic [AB-1:0]    ld_addr_dc1, ld_end_addr_dc1;
  logic             sb_valid, sb_commit;
  logic [AB-1:0]    sb_addr;
  logic [FD-1:0]    sb_wdata;
  logic             corr_valid_dc3, corr_overflow;
  logic [AB-1:0]    corr_addr_dc3;
  logic [FD-1:0]    corr_wdata_dc3;
  logic [NB-1:0]    bank_rden, bank_wren;
  logic [NB*AB-1:0] bank_addr;
  logic [NB*FD-1:0] bank_wdata, bank_rdata;
  logic             rd_valid_dc3;
  logic [FD-1:0]    rd_data_lo_dc3, rd_data_hi_dc3;

  int total = 0;
  int bad   = 0;
  logic [2*FD-1:0] exp_q [$];
  logic [FD-1:0]   mem_rd [NB];

  lsu_dccm_bank_arb #(
    .DATA_WIDTH(DW), .ECC_WIDTH(EW), .NUM_BANKS(NB),
    .ADDR_BITS(AB), .STARVE_MAX(SM), .CORR_DEPTH(CD)
  ) dut (
    .clk(clk), .rst_l(rst_l), .freeze(freeze),
    .ld_valid_dc1(ld_valid_dc1), .ld_addr_dc1(ld_addr_dc1),
    .ld_end_addr_dc1(ld_end_addr_dc1), .ld_stall_dc1(ld_stall_dc1),
    .sb_valid(sb_valid), .sb_addr(sb_addr), .sb_wdata(sb_wdata), .sb_commit(sb_commit),
    .corr_valid_dc3(corr_valid_dc3), .corr_addr_dc3(corr_addr_dc3),
    .corr_wdata_dc3(corr_wdata_dc3), .corr_overflow(corr_overflow),
    .bank_rden(bank_rden), .bank_wren(bank_wren), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
    .rd_valid_dc3(rd_valid_dc3), .rd_data_lo_dc3(rd_data_lo_dc3),
    .rd_data_hi_dc3(rd_data_hi_dc3)
  );

  always #5 clk = ~clk;

  // Bank word content is a fixed function of bank and address.
  function automatic logic [FD-1:0] pat(int b, logic [AB-1:0] a);
    return {7'(b * 5 + 1), a, ~a};
  endfunction

  initial for (int b = 0; b < NB; b++) mem_rd[b] = '0;
  always @(posedge clk)
    for (int b = 0; b < NB; b++)
      if (bank_rden[b]) mem_rd[b] <= pat(b, bank_addr[b*AB +: AB]);
  always_comb for (int b = 0; b < NB; b++) bank_rdata[b*FD +: FD] = mem_rd[b];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_l && !freeze && rd_valid_dc3) begin
      if (exp_q.size() == 0) chk("rd_spurious", 64'(rd_valid_dc3), 64'd0);
      else begin
        logic [2*FD-1:0] e;
        e = exp_q.pop_front();
        chk("rd_lo", 64'(rd_data_lo_dc3), 64'(e[2*FD-1:FD]));
        chk("rd_hi", 64'(rd_data_hi_dc3), 64'(e[FD-1:0]));
      end
    end
  end

  task automatic idle();
    freeze = 0; ld_valid_dc1 = 0; ld_addr_dc1 = '0; ld_end_addr_dc1 = '0;
    sb_valid = 0; sb_addr = '0; sb_wdata = '0;
    corr_valid_dc3 = 0; corr_addr_dc3 = '0; corr_wdata_dc3 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AB-1:0] a, input logic [AB-1:0] e);
    ld_valid_dc1 = 1; ld_addr_dc1 = a; ld_end_addr_dc1 = e;
  endtask

  task automatic store(input logic [AB-1:0] a, input logic [FD-1:0] d);
    sb_valid = 1; sb_addr = a; sb_wdata = d;
  endtask

  task automatic corr(input logic [AB-1:0] a, input logic [FD-1:0] d);
    corr_valid_dc3 = 1; corr_addr_dc3 = a; corr_wdata_dc3 = d;
  endtask

  task automatic chk_wr(input string tag, input int b, input logic [AB-1:0] a,
                        input logic [FD-1:0] d);
    chk({tag, "_wren"}, 64'(bank_wren), 64'(1 << b));
    chk({tag, "_addr"}, 64'(bank_addr[b*AB +: AB]), 64'(a));
    chk({tag, "_wdata"}, 64'(bank_wdata[b*FD +: FD]), 64'(d));
  endtask

  initial begin
    rst_l = 0;
    idle();
    tick();
    chk("rst_stall", 64'(ld_stall_dc1), 0);
    chk("rst_commit", 64'(sb_commit), 0);
    chk("rst_rden", 64'(bank_rden), 0);
    chk("rst_wren", 64'(bank_wren), 0);
    chk("rst_addr", 64'(bank_addr), 0);
    chk("rst_rdv", 64'(rd_valid_dc3), 0);
    chk("rst_ovf", 64'(corr_overflow), 0);
    chk("rst_rdlo", 64'(rd_data_lo_dc3), 0);
    #3 rst_l = 1;
    tick();

    // Load bank 0 and store bank 2 together.
    load(16'h0, 16'h3); store(16'h8, 39'h11_2233_4455);
    #1;
    chk("t1_rden", 64'(bank_rden), 64'b0001);
    chk("t1_stall", 64'(ld_stall_dc1), 0);
    chk("t1_commit", 64'(sb_commit), 1);
    chk_wr("t1", 2, 16'h8, 39'h11_2233_4455);
    exp_q.push_back({pat(0, 16'h0), pat(0, 16'h0)});
    tick(); idle(); #1;
    chk("t1_rdv_n1", 64'(rd_valid_dc3), 0);
    tick();
    chk("t1_rdv_n2", 64'(rd_valid_dc3), 1);
    tick();

    // Store to a bank the load also needs: starves for STARVE_MAX cycles.
    load(16'h2, 16'h5); store(16'h4, 39'h0a_0b0c_0d0e);
    for (int i = 0; i < SM; i++) begin
      #1;
      chk("t2_commit", 64'(sb_commit), 0);
      chk("t2_stall", 64'(ld_stall_dc1), 0);
      chk("t2_rden", 64'(bank_rden), 64'b0011);
      exp_q.push_back({pat(0, 16'h2), pat(1, 16'h5)});
      tick();
    end
    #1;
    chk("t2_starve_commit", 64'(sb_commit), 1);
    chk("t2_starve_stall", 64'(ld_stall_dc1), 1);
    chk("t2_starve_rden", 64'(bank_rden), 0);
    chk_wr("t2_starve", 1, 16'h4, 39'h0a_0b0c_0d0e);
    tick(); #1;
    chk("t2_after_commit", 64'(sb_commit), 0);
    chk("t2_after_stall", 64'(ld_stall_dc1), 0);
    exp_q.push_back({pat(0, 16'h2), pat(1, 16'h5)});
    tick(); idle();
    repeat (3) tick();

    // Queued correction beats the store buffer.
    corr(16'h10, 39'h7f_0000_0001); #1;
    chk("t3_push_wren", 64'(bank_wren), 0);
    tick(); idle(); store(16'h14, 39'h22_3333_4444); #1;
    chk("t3_corr_commit", 64'(sb_commit), 0);
    chk_wr("t3_corr", 0, 16'h10, 39'h7f_0000_0001);
    tick(); #1;
    chk("t3_sb_commit", 64'(sb_commit), 1);
    chk_wr("t3_sb", 1, 16'h14, 39'h22_3333_4444);
    tick(); idle(); tick();

    // Fill the queue under freeze, overflow the third push, then push at full with a pop.
    freeze = 1; corr(16'h20, 39'h01); #1;
    chk("t4_frz_wren", 64'(bank_wren), 0);
    tick(); corr(16'h24, 39'h02); #1;
    chk("t4_ovf0", 64'(corr_overflow), 0);
    tick(); corr(16'h28, 39'h03); tick();
    freeze = 0; corr(16'h2c, 39'h04); #1;
    chk("t4_ovf1", 64'(corr_overflow), 1);
    chk_wr("t4_q0", 0, 16'h20, 39'h01);
    tick(); idle(); #1;
    chk("t4_ovf_pulse", 64'(corr_overflow), 0);
    chk_wr("t4_q1", 1, 16'h24, 39'h02);
    tick();
    chk_wr("t4_q2", 3, 16'h2c, 39'h04);
    tick();
    chk("t4_empty_wren", 64'(bank_wren), 0);
    tick();

    // Freeze for three cycles behind a granted load.
    load(16'h40, 16'h43); #1;
    chk("t5_rden", 64'(bank_rden), 64'b0001);
    exp_q.push_back({pat(0, 16'h40), pat(0, 16'h40)});
    tick(); idle(); freeze = 1; load(16'h44, 16'h47); store(16'h48, 39'h5); #1;
    chk("t5_frz_stall", 64'(ld_stall_dc1), 1);
    chk("t5_frz_rden", 64'(bank_rden), 0);
    chk("t5_frz_wren", 64'(bank_wren), 0);
    chk("t5_frz_commit", 64'(sb_commit), 0);
    tick(); idle(); freeze = 1; #1;
    chk("t5_frz2_rdv", 64'(rd_valid_dc3), 0);
    tick(); #1;
    chk("t5_frz3_rdv", 64'(rd_valid_dc3), 0);
    tick(); idle(); #1;
    chk("t5_n4_rdv", 64'(rd_valid_dc3), 0);
    tick();
    chk("t5_n5_rdv", 64'(rd_valid_dc3), 1);
    tick(); tick();

    // Reset with a load in DC2: it must vanish.
    load(16'h80, 16'h83); tick(); idle(); #1;
    rst_l = 0; #1;
    chk("t6_rst_rdv", 64'(rd_valid_dc3), 0);
    tick();
    chk("t6_rst_rdv2", 64'(rd_valid_dc3), 0);
    #2 rst_l = 1;
    tick();
    chk("t6_rel_rdv", 64'(rd_valid_dc3), 0);
    tick();
    chk("t6_rel_rdv2", 64'(rd_valid_dc3), 0);
    chk("t6_rel_rdlo", 64'(rd_data_lo_dc3), 0);
    chk("t6_rel_rdhi", 64'(rd_data_hi_dc3), 0);
    tick();

    chk("sb_drained", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
